demux8_stage: RTL and testbench



---
 rtl/demux8_pkg.sv | 10 +
 rtl/dec3to8.sv | 10 +
 rtl/demux8_stage.sv | 71 +++++++
 tb/tb_demux8_stage.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/demux8_pkg.sv
// demux8_pkg: shared sizes, state encoding and pointer helper for demux8_stage
package demux8_pkg;
    localparam int NUM_OUT = 8;
    localparam int SEL_W = 3;
    localparam logic EMPTY = 1'b0;
    localparam logic FULL = 1'b1;
    function automatic logic [SEL_W-1:0] next_rr(input logic [SEL_W-1:0] p);
        return p + 1'b1;
    endfunction
endpackage

// File: rtl/dec3to8.sv
// dec3to8: one-hot 3-to-8 decoder with enable
module dec3to8
    import demux8_pkg::*;
(
    input  logic               en,
    input  logic [SEL_W-1:0]   sel,
    output logic [NUM_OUT-1:0] y
);
    always_comb y = en ? ({{(NUM_OUT-1){1'b0}}, 1'b1} << sel) : '0;
endmodule

// File: rtl/demux8_stage.sv
// demux8_stage: registered 1-to-8 valid/ready demux; DEMUX8_AUTOSEL_EN selects lanes round-robin
module demux8_stage
    import demux8_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic [WIDTH-1:0]   In,
    input  logic [SEL_W-1:0]   Select,
    input  logic               InValid,
    output logic               InReady,
    output logic [WIDTH-1:0]   Out1,
    output logic [WIDTH-1:0]   Out2,
    output logic [WIDTH-1:0]   Out3,
    output logic [WIDTH-1:0]   Out4,
    output logic [WIDTH-1:0]   Out5,
    output logic [WIDTH-1:0]   Out6,
    output logic [WIDTH-1:0]   Out7,
    output logic [WIDTH-1:0]   Out8,
    output logic [NUM_OUT-1:0] OutValid,
    input  logic [NUM_OUT-1:0] OutReady
);
    logic             full_q, full_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [SEL_W-1:0] sel_q, sel_d, pick;
    logic             accept, deliver;
    logic [NUM_OUT-1:0] lane_en;
    logic [WIDTH-1:0] lane_data [NUM_OUT];
`ifdef DEMUX8_AUTOSEL_EN
    logic [SEL_W-1:0] rr_q, rr_d;
    assign pick = rr_q;
    always_comb rr_d = accept ? next_rr(rr_q) : rr_q;
    always_ff @(posedge Clk)
        rr_q <= Reset ? '0 : rr_d;
`else
    assign pick = Select;
`endif
    always_comb begin
        InReady = !Reset & (!full_q | OutReady[sel_q]);
        accept  = InValid & InReady;
        deliver = full_q & OutReady[sel_q];
        full_d  = accept ? FULL : deliver ? EMPTY : full_q;
        data_d  = accept ? In : data_q;
        sel_d   = accept ? pick : sel_q;
    end
    always_ff @(posedge Clk) begin
        if (Reset) begin
            full_q <= EMPTY;
            data_q <= '0;
            sel_q  <= '0;
        end else begin
            full_q <= full_d;
            data_q <= data_d;
            sel_q  <= sel_d;
        end
    end
    dec3to8 u_dec (.en(full_q), .sel(sel_q), .y(lane_en));
    assign OutValid = lane_en;
    for (genvar k = 0; k < NUM_OUT; k++) begin : g_lane
        assign lane_data[k] = lane_en[k] ? data_q : '0;
    end
    assign Out1 = lane_data[0];
    assign Out2 = lane_data[1];
    assign Out3 = lane_data[2];
    assign Out4 = lane_data[3];
    assign Out5 = lane_data[4];
    assign Out6 = lane_data[5];
    assign Out7 = lane_data[6];
    assign Out8 = lane_data[7];
endmodule

// File: tb/tb_demux8_stage.sv
// tb_demux8_stage: scoreboard bench for demux8_stage
module tb_demux8_stage;
    localparam int W = 8;
    logic         Clk = 0, Reset = 1, InValid = 0, InReady;
    logic [W-1:0] In = 0;
    logic [2:0]   Select = 0;
    logic [W-1:0] Out1, Out2, Out3, Out4, Out5, Out6, Out7, Out8;
    logic [7:0]   OutValid, OutReady = 8'hFF;
    int           checks = 0, errors = 0;
    logic [2:0]   rr = 0, last_lane = 0;
    logic [10:0]  q [$];

    demux8_stage #(.WIDTH(W)) dut (
        .Clk(Clk), .Reset(Reset), .In(In), .Select(Select), .InValid(InValid), .InReady(InReady),
        .Out1(Out1), .Out2(Out2), .Out3(Out3), .Out4(Out4), .Out5(Out5), .Out6(Out6), .Out7(Out7),
        .Out8(Out8), .OutValid(OutValid), .OutReady(OutReady)
    );

    always #5 Clk = ~Clk;

    wire [63:0] bus = {Out8, Out7, Out6, Out5, Out4, Out3, Out2, Out1};

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge Clk);
        #1;
    endtask

    function automatic logic [2:0] exp_lane(input logic [2:0] sel);
`ifdef DEMUX8_AUTOSEL_EN
        return rr;
`else
        return sel;
`endif
    endfunction

    task automatic push(input logic [W-1:0] d, input logic [2:0] sel);
        last_lane = exp_lane(sel);
        q.push_back({last_lane, d});
        rr = rr + 3'd1;
    endtask

    // drive one word, wait for the handshake at the negedge, leave inputs idle after the edge
    task automatic send(input logic [W-1:0] d, input logic [2:0] sel);
        bit done = 0;
        In = d; Select = sel; InValid = 1;
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge Clk);
            if (InReady) begin
                push(d, sel);
                done = 1;
            end else begin
                @(posedge Clk);
                #1;
            end
        end
        if (!done) chk("send_timeout", 0, 1);
        tick();
        InValid = 0;
    endtask

    // monitor: every delivery pops the oldest expected word
    always @(negedge Clk) begin
        if (!Reset && (OutValid & OutReady) != 0) begin
            if (q.size() == 0) chk("unexpected_delivery", {56'd0, OutValid}, 0);
            else begin
                logic [10:0] e;
                e = q.pop_front();
                chk("deliver_valid", {56'd0, OutValid}, {56'd0, 8'b1 << e[10:8]});
                chk("deliver_data", bus, {56'd0, e[7:0]} << (8 * e[10:8]));
            end
        end
    end

    initial begin
        In = 8'h5A; Select = 3; InValid = 1;
        for (int i = 0; i < 2; i++) begin
            @(negedge Clk);
            chk("reset_inready", {63'd0, InReady}, 0);
            chk("reset_outvalid", {56'd0, OutValid}, 0);
            chk("reset_outs", bus, 0);
            tick();
        end
        Reset = 0; InValid = 0;
        @(negedge Clk);
        chk("post_reset_inready", {63'd0, InReady}, 1);
        chk("post_reset_outvalid", {56'd0, OutValid}, 0);
        tick();

        send(8'h01, 3'b101);
        @(negedge Clk);
        chk("single_valid", {56'd0, OutValid}, {56'd0, 8'b1 << last_lane});
        chk("single_outs", bus, 64'h01 << (8 * last_lane));
        tick();
        @(negedge Clk);
        chk("single_drop", {56'd0, OutValid}, 0);
        chk("single_drop_outs", bus, 0);
        tick();

        OutReady = 8'h00;
        send(8'hA5, 3'b010);
        In = 8'h3C; Select = 3'b111; InValid = 1;
        for (int i = 0; i < 4; i++) begin
            OutReady = (i < 2) ? 8'h00 : ~(8'b1 << last_lane);
            @(negedge Clk);
            chk("bp_valid", {56'd0, OutValid}, {56'd0, 8'b1 << last_lane});
            chk("bp_data", bus, 64'hA5 << (8 * last_lane));
            chk("bp_inready", {63'd0, InReady}, 0);
            tick();
        end
        InValid = 0; OutReady = 8'b1 << last_lane;
        @(negedge Clk);
        chk("bp_release_inready", {63'd0, InReady}, 1);
        tick();
        @(negedge Clk);
        chk("bp_empty", {56'd0, OutValid}, 0);
        tick();

        OutReady = 8'hFF;
        for (int i = 0; i < 8; i++) begin
            logic [2:0] prev;
            prev = last_lane;
            In = W'(i * 17 + 3); Select = 3'(i); InValid = 1;
            @(negedge Clk);
            chk("b2b_inready", {63'd0, InReady}, 1);
            chk("b2b_valid", {56'd0, OutValid}, i == 0 ? 64'd0 : {56'd0, 8'b1 << prev});
            push(W'(i * 17 + 3), 3'(i));
            tick();
        end
        InValid = 0;
        @(negedge Clk);
        chk("b2b_last", {56'd0, OutValid}, {56'd0, 8'b1 << last_lane});
        tick();
        @(negedge Clk);
        chk("b2b_empty", {56'd0, OutValid}, 0);
        tick();

        OutReady = 8'h00;
        send(8'h77, 3'b111);
        @(negedge Clk);
        chk("mid_held", {56'd0, OutValid}, {56'd0, 8'b1 << last_lane});
        tick();
        Reset = 1;
        @(negedge Clk);
        chk("mid_reset_inready", {63'd0, InReady}, 0);
        void'(q.pop_back());
        rr = 0;
        tick();
        Reset = 0; OutReady = 8'hFF;
        @(negedge Clk);
        chk("mid_reset_valid", {56'd0, OutValid}, 0);
        chk("mid_reset_outs", bus, 0);
        chk("mid_reset_inready_after", {63'd0, InReady}, 1);
        tick();

        for (int i = 0; i < 10; i++) send(W'(8'hC0 + i), 3'b011);
        repeat (3) tick();
        chk("queue_empty", 64'(q.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
